// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-sequence encoder: instruction field
// positions, default opcodes, FSM state and class types, and word packing.
package imm_pkg;

    localparam int OPC_MSB   = 29;
    localparam int OPC_LSB   = 26;
    localparam int RD_MSB    = 25;
    localparam int RD_LSB    = 22;
    localparam int IMM12_MSB = 11;
    localparam int IMM12_LSB = 0;

    localparam logic [3:0] DEF_OP_MOV8  = 4'h1;
    localparam logic [3:0] DEF_OP_MOV12 = 4'h2;
    localparam logic [3:0] DEF_OP_SHLOR = 4'h3;

    typedef enum logic [2:0] {IDLE, SINGLE, HI, MID, LO} imm_seq_state_t;
    typedef enum logic [1:0] {C_MOV8, C_MOV12, C_LONG} imm_class_t;

    // Bits [21:12] are always zero in every emitted word.
    function automatic logic [29:0] pack_instr(input logic [3:0]  op,
                                               input logic [3:0]  rd,
                                               input logic [11:0] imm12);
        logic [29:0] w;
        w = '0;
        w[OPC_MSB:OPC_LSB]     = op;
        w[RD_MSB:RD_LSB]       = rd;
        w[IMM12_MSB:IMM12_LSB] = imm12;
        return w;
    endfunction

endpackage

// File: rtl/imm_classify.sv
// Picks the shortest encoding class for a 30-bit constant.
module imm_classify
    import imm_pkg::*;
(
    input  logic [29:0] value,
    input  logic        force_long,
    output imm_class_t  cls
);

    always_comb begin
        cls = C_LONG;
        if (!force_long) begin
            if (value[29:8] == '0) begin
                cls = C_MOV8;
            end else if (value[29:12] == '0) begin
                cls = C_MOV12;
            end
        end
    end

endmodule

// File: rtl/imm_seq_encoder.sv
// Converts a constant plus destination register into a 1- or 3-word
// move-immediate sequence; every output comes straight from a flop.
module imm_seq_encoder
    import imm_pkg::*;
#(
    parameter logic [3:0] OP_MOV8  = DEF_OP_MOV8,
    parameter logic [3:0] OP_MOV12 = DEF_OP_MOV12,
    parameter logic [3:0] OP_SHLOR = DEF_OP_SHLOR
) (
    input  logic           clk,
    input  logic           reset_n,
    // valid/ready: a beat transfers on a rising edge where both are high;
    // a producer holding valid keeps its payload stable until that edge.
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [29:0]    req_value,
    input  logic [3:0]     req_rd,
    input  logic           req_force_long,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [29:0]    out_instr,
    output logic           out_last,
    output logic [7:0]     seq_count,
    output imm_seq_state_t state
);

    imm_seq_state_t state_q, state_d;
    imm_class_t     cls;
    logic [23:0]    val_q, val_d;
    logic [3:0]     rd_q, rd_d;
    logic [29:0]    instr_d;
    logic           valid_d, last_d, ready_d;

    imm_classify u_classify (
        .value      (req_value),
        .force_long (req_force_long),
        .cls        (cls)
    );

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rd_d    = rd_q;
        instr_d = out_instr;
        valid_d = out_valid;
        last_d  = out_last;
        ready_d = req_ready;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    val_d   = req_value[23:0];
                    rd_d    = req_rd;
                    valid_d = 1'b1;
                    ready_d = 1'b0;
                    case (cls)
                        C_MOV8: begin
                            instr_d = pack_instr(OP_MOV8, req_rd, {4'b0, req_value[7:0]});
                            last_d  = 1'b1;
                            state_d = SINGLE;
                        end
                        C_MOV12: begin
                            instr_d = pack_instr(OP_MOV12, req_rd, req_value[11:0]);
                            last_d  = 1'b1;
                            state_d = SINGLE;
                        end
                        default: begin
                            instr_d = pack_instr(OP_MOV12, req_rd, {6'b0, req_value[29:24]});
                            last_d  = 1'b0;
                            state_d = HI;
                        end
                    endcase
                end
            end
            HI: begin
                if (out_ready) begin
                    instr_d = pack_instr(OP_SHLOR, rd_q, val_q[23:12]);
                    state_d = MID;
                end
            end
            MID: begin
                if (out_ready) begin
                    instr_d = pack_instr(OP_SHLOR, rd_q, val_q[11:0]);
                    last_d  = 1'b1;
                    state_d = LO;
                end
            end
            SINGLE, LO: begin
                // The final handshake only returns to IDLE; a new request
                // is taken no earlier than the following edge.
                if (out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            val_q     <= '0;
            rd_q      <= '0;
            out_instr <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            req_ready <= 1'b1;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            rd_q      <= rd_d;
            out_instr <= instr_d;
            out_valid <= valid_d;
            out_last  <= last_d;
            req_ready <= ready_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_count <= '0;
        end else if (out_valid && out_ready && out_last && (seq_count != 8'hFF)) begin
            seq_count <= seq_count + 8'd1;
        end
    end

    assign state = state_q;

endmodule
